sram_dualport_init: RTL and testbench
=====================================

# sram_dualport_init

Parametrised simple-dual-port SRAM (one write port, one read port, one clock) with per-byte write enables, a selectable read-during-write mode, an optional output pipeline register, and a built-in initialisation sweep that writes a known value to every word after reset or on request. It is the storage primitive for FIFOs and buffers that need a defined memory state without relying on a simulator or FPGA init file. A `busy_o` flag gates client traffic while the sweep runs.

## Interface
- `WIDTH`, 32: data width in bits; must be a multiple of 8.
- `DEPTH`, 16: number of words; need not be a power of 2; must be ≥ 2.
- `ADDR_W`, `$clog2(DEPTH)`: address width.
- `BE_W`, `WIDTH/8`: byte-enable width.
- `RDW_MODE`, 0: same-address read-during-write result; 0 = old data, 1 = new (merged) data.
- `OUT_REG`, 0: 1 adds one output register stage.
- `INIT_VAL`, `'0`: `WIDTH`-bit value written to every word by the sweep.

Ports:
- `clk_i`, in, 1: clock; all logic on the rising edge.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `clear_i`, in, 1: request a new init sweep.
- `busy_o`, out, 1: sweep in progress; client requests are ignored.
- `wen_i`, in, 1: write request.
- `be_i`, in, `BE_W`: byte enables; bit k covers `data_i[8k+7:8k]`.
- `waddr_i`, in, `ADDR_W`: write address.
- `data_i`, in, `WIDTH`: write data.
- `ren_i`, in, 1: read request.
- `raddr_i`, in, `ADDR_W`: read address.
- `data_o`, out, `WIDTH`: read data.
- `valid_o`, out, 1: one-cycle pulse marking `data_o` as valid for an accepted read.

## Operation
- **States:** SWEEP and IDLE.
  - `rst_i` forces SWEEP with sweep pointer = 0.
- **SWEEP:**
  - Each rising edge writes `INIT_VAL` to the address held in the sweep pointer, then increments the pointer.
  - The edge that writes address `DEPTH-1` moves the block to IDLE.
  - `busy_o` = 1 throughout SWEEP.
  - `wen_i`, `ren_i` and `clear_i` are ignored; no `valid_o` is generated.
- **IDLE:**
  - `busy_o` = 0.
  - `clear_i` = 1 at an edge moves the block to SWEEP with pointer = 0.
  - A write or read presented in that same cycle is still performed (the write is later overwritten by the sweep).
- **Write:**
  - Happens when `wen_i` = 1 in IDLE.
  - Only bytes with `be_i[k]` = 1 are updated; `be_i` = 0 is a no-op.
  - `waddr_i` ≥ `DEPTH` is dropped.
- **Read:**
  - Happens when `ren_i` = 1 in IDLE.
  - Returns the word at `raddr_i`.
  - `raddr_i` ≥ `DEPTH` returns all zeros, with `valid_o` still asserted.
- **Read-during-write, same address, same cycle:**
  - `RDW_MODE` = 0 returns the pre-write word.
  - `RDW_MODE` = 1 returns the merged word: enabled bytes from `data_i`, the other bytes from the old contents.
- **Output hold:** `data_o` holds its last value when no read completes.
- **Memory reset:** the memory array has no reset of its own; only the sweep defines its contents.

## Timing
- **Reset values:**
  - `busy_o` = 1.
  - `valid_o` = 0.
  - `data_o` = 0.
  - Output pipeline register and its valid bit = 0.
- **Sweep length:**
  - The sweep occupies exactly `DEPTH` rising edges after `rst_i` deasserts.
  - `busy_o` falls after the `DEPTH`-th edge.
  - The first request accepted is the one presented in the first cycle with `busy_o` = 0.
- **Sweep after `clear_i`:**
  - `busy_o` rises after the edge that samples `clear_i`.
  - The sweep then spans the next `DEPTH` edges.
- **Read latency** (edges from the sampling edge to `data_o`/`valid_o` updating):
  - `OUT_REG` = 0: 1 edge.
  - `OUT_REG` = 1: 2 edges.
- **Read throughput:** back-to-back reads give one `valid_o` per cycle, in order.
- **Write visibility:** a write is visible to a different-address read one cycle later, and to a same-address read in the same cycle per `RDW_MODE`.
- **Reset mid-sweep:** `rst_i` asserted mid-sweep restarts the sweep from address 0 once it is released.
- **Reset with reads in flight:** `rst_i` clears in-flight reads; no `valid_o` follows.
- **`clear_i` during SWEEP:** ignored; the pointer does not restart.
- **Reads in flight at `clear_i`:** a read accepted in the same cycle as `clear_i` still completes with `valid_o` during the sweep, with normal latency.

## Test plan
- **Reset sweep** (`WIDTH`=32, `DEPTH`=16, `INIT_VAL`=`32'hA5A5A5A5`):
  - Stimulus: release reset, then read addresses 0..15.
  - Required: `busy_o` is high for exactly 16 cycles; every read returns `A5A5A5A5` with `valid_o`; `data_o` = 0 before the first read.
- **Byte enables:**
  - Stimulus: write `32'h11223344` with `be_i`=`4'b0101` to address 3 (old value `A5A5A5A5`), then read address 3.
  - Required: `data_o` = `A522A544`, one edge after the read with `OUT_REG`=0.
- **Read-during-write:**
  - Stimulus: same-cycle write of `32'hDEADBEEF` (`be_i`=`4'hF`) and read, both to address 5 (old value 0).
  - Required: `RDW_MODE`=0 returns 0; `RDW_MODE`=1 returns `DEADBEEF`.
- **Output register and streaming** (`OUT_REG`=1):
  - Stimulus: 4 back-to-back reads of addresses 0..3.
  - Required: 4 consecutive `valid_o` pulses starting 2 edges after the first request, data in order.
- **`clear_i` behaviour:**
  - Stimulus: in IDLE, pulse `clear_i` together with a read of address 2; pulse `clear_i` again mid-sweep; issue writes during the sweep.
  - Required: the address-2 read completes; the sweep lasts exactly `DEPTH` cycles from the first pulse; the second pulse and the writes have no effect; all words equal `INIT_VAL` afterwards.
- **Non-power-of-2 depth and reset mid-sweep** (`DEPTH`=10):
  - Stimulus: assert `rst_i` at sweep cycle 4, release it, then write/read address 12.
  - Required: a full 10-cycle sweep follows release; the write to address 12 is dropped; the read of address 12 returns 0 with `valid_o`.

Source files
------------

// File: rtl/sram_dualport_init.sv
// Simple-dual-port SRAM with per-byte write enables and a sweep that writes INIT_VAL to every word after reset or clear_i.
// Read latency is 1 edge (2 with OUT_REG); client requests are ignored while busy_o is high.
module sram_dualport_init #(
    parameter int              WIDTH    = 32,
    parameter int              DEPTH    = 16,
    parameter int              ADDR_W   = $clog2(DEPTH),
    parameter int              BE_W     = WIDTH / 8,
    parameter int              RDW_MODE = 0,
    parameter int              OUT_REG  = 0,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    output logic              busy_o,
    input  logic              wen_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  data_i,
    input  logic              ren_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  data_o,
    output logic              valid_o
);

    typedef enum logic {ST_SWEEP, ST_IDLE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_L   = DEPTH[ADDR_W:0];

    state_t              r_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic                r_busy;
    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic                r_rd_vld;
    logic [WIDTH-1:0]    r_rd_dat;

    logic                w_idle;
    logic                w_waddr_ok;
    logic                w_raddr_ok;
    logic                w_wr_ok;
    logic                w_rd_ok;
    logic                w_rdw_hit;
    logic [WIDTH-1:0]    w_old;
    logic [WIDTH-1:0]    w_merged;
    logic [WIDTH-1:0]    w_rd_word;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_waddr_ok = ({1'b0, waddr_i} < DEPTH_L);
    assign w_raddr_ok = ({1'b0, raddr_i} < DEPTH_L);
    assign w_wr_ok    = w_idle && wen_i && w_waddr_ok;
    assign w_rd_ok    = w_idle && ren_i;
    assign w_old      = w_raddr_ok ? r_mem[raddr_i] : '0;
    // An invalid read address can never match an accepted write, so the bypass needs no extra guard.
    assign w_rdw_hit  = (RDW_MODE != 0) && w_wr_ok && (waddr_i == raddr_i);
    assign w_rd_word  = w_rdw_hit ? w_merged : w_old;
    assign busy_o     = r_busy;

    always_comb begin
        w_merged = w_old;
        for (int k = 0; k < BE_W; k++) begin
            if (be_i[k]) begin
                w_merged[8*k +: 8] = data_i[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_SWEEP;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                ST_SWEEP: begin
                    if (r_ptr == LAST_ADDR) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (clear_i) begin
                        r_state <= ST_SWEEP;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Storage has no reset; its contents are defined only by the sweep.
    always_ff @(posedge clk_i) begin
        if (r_state == ST_SWEEP) begin
            r_mem[r_ptr] <= INIT_VAL;
        end else if (w_wr_ok) begin
            for (int k = 0; k < BE_W; k++) begin
                if (be_i[k]) begin
                    r_mem[waddr_i][8*k +: 8] <= data_i[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_vld <= 1'b0;
            r_rd_dat <= '0;
        end else begin
            r_rd_vld <= w_rd_ok;
            if (w_rd_ok) begin
                r_rd_dat <= w_rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic             r_out_vld;
            logic [WIDTH-1:0] r_out_dat;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_out_vld <= 1'b0;
                    r_out_dat <= '0;
                end else begin
                    r_out_vld <= r_rd_vld;
                    if (r_rd_vld) begin
                        r_out_dat <= r_rd_dat;
                    end
                end
            end

            assign valid_o = r_out_vld;
            assign data_o  = r_out_dat;
        end else begin : g_no_out_reg
            assign valid_o = r_rd_vld;
            assign data_o  = r_rd_dat;
        end
    endgenerate

endmodule

// File: tb/tb_sram_dualport_init.sv
// Directed bench: four instances (old/new read-during-write, output register, depth 10) share one stimulus stream.
module tb_sram_dualport_init;

    localparam logic [31:0] IV = 32'hA5A5A5A5;

    logic        clk;
    logic        rst;
    logic        rst3;
    logic        clear;
    logic        wen;
    logic [3:0]  be;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic        ren;
    logic [3:0]  raddr;

    logic        busy0, busy1, busy2, busy3;
    logic        vld0, vld1, vld2, vld3;
    logic [31:0] dat0, dat1, dat2, dat3;

    int checks   = 0;
    int failures = 0;

    sram_dualport_init #(.WIDTH(32), .DEPTH(16), .RDW_MODE(0), .OUT_REG(0), .INIT_VAL(IV)) u0 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .busy_o(busy0),
        .wen_i(wen), .be_i(be), .waddr_i(waddr), .data_i(wdata),
        .ren_i(ren), .raddr_i(raddr), .data_o(dat0), .valid_o(vld0));

    sram_dualport_init #(.WIDTH(32), .DEPTH(16), .RDW_MODE(1), .OUT_REG(0), .INIT_VAL(IV)) u1 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .busy_o(busy1),
        .wen_i(wen), .be_i(be), .waddr_i(waddr), .data_i(wdata),
        .ren_i(ren), .raddr_i(raddr), .data_o(dat1), .valid_o(vld1));

    sram_dualport_init #(.WIDTH(32), .DEPTH(16), .RDW_MODE(0), .OUT_REG(1), .INIT_VAL(IV)) u2 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .busy_o(busy2),
        .wen_i(wen), .be_i(be), .waddr_i(waddr), .data_i(wdata),
        .ren_i(ren), .raddr_i(raddr), .data_o(dat2), .valid_o(vld2));

    sram_dualport_init #(.WIDTH(32), .DEPTH(10), .RDW_MODE(0), .OUT_REG(0), .INIT_VAL(IV)) u3 (
        .clk_i(clk), .rst_i(rst3), .clear_i(clear), .busy_o(busy3),
        .wen_i(wen), .be_i(be), .waddr_i(waddr), .data_i(wdata),
        .ren_i(ren), .raddr_i(raddr), .data_o(dat3), .valid_o(vld3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [3:0]  be;
        logic [3:0]  waddr;
        logic [31:0] data;
        logic        ren;
        logic [3:0]  raddr;
        logic        exp_vld;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wen = 1'b0; be = 4'h0; waddr = 4'h0; wdata = 32'h0;
        ren = 1'b0; raddr = 4'h0; clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n0, n3, n;
        logic        pv;
        logic [31:0] pd;

        // reads 0..15 after the sweep, then byte enables, RDW and be=0 cases
        for (int i = 0; i < 16; i++)
            vecs.push_back('{1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(i), 1'b1, IV, IV});
        vecs.push_back('{1'b1, 4'b0101, 4'd3, 32'h11223344, 1'b0, 4'd0, 1'b0, IV, IV});
        vecs.push_back('{1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd3, 1'b1, 32'hA522A544, 32'hA522A544});
        vecs.push_back('{1'b1, 4'hF, 4'd5, 32'h0, 1'b0, 4'd0, 1'b0, 32'hA522A544, 32'hA522A544});
        vecs.push_back('{1'b1, 4'hF, 4'd5, 32'hDEADBEEF, 1'b1, 4'd5, 1'b1, 32'h0, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd5, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 4'h0, 4'd4, 32'hFFFFFFFF, 1'b1, 4'd6, 1'b1, IV, IV});
        vecs.push_back('{1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd4, 1'b1, IV, IV});
        vecs.push_back('{1'b1, 4'b1000, 4'd8, 32'h12345678, 1'b1, 4'd9, 1'b1, IV, IV});
        vecs.push_back('{1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd8, 1'b1, 32'h12A5A5A5, 32'h12A5A5A5});
        vecs.push_back('{1'b1, 4'hF, 4'd2, 32'hCAFEF00D, 1'b0, 4'd0, 1'b0, 32'h12A5A5A5, 32'h12A5A5A5});
        vecs.push_back('{1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd2, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D});

        idle_inputs();
        rst = 1'b1; rst3 = 1'b1;
        tick(); tick();
        chk("rst_busy0", 32'(busy0), 32'd1);
        chk("rst_vld0", 32'(vld0), 32'd0);
        chk("rst_dat0", dat0, 32'h0);
        chk("rst_vld2", 32'(vld2), 32'd0);
        chk("rst_dat2", dat2, 32'h0);

        // reset sweep length: 16 edges for depth 16, 10 for depth 10
        rst = 1'b0; rst3 = 1'b0;
        n0 = 0; n3 = 0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (n0 == 0 && !busy0) n0 = e;
            if (n3 == 0 && !busy3) n3 = e;
            if (vld0) chk("sweep_no_valid", 32'(vld0), 32'd0);
        end
        chk("sweep_len16", 32'(n0), 32'd16);
        chk("sweep_len10", 32'(n3), 32'd10);
        chk("data_before_read", dat0, 32'h0);

        pv = 1'b0; pd = 32'h0;
        foreach (vecs[i]) begin
            wen = vecs[i].wen; be = vecs[i].be; waddr = vecs[i].waddr; wdata = vecs[i].data;
            ren = vecs[i].ren; raddr = vecs[i].raddr;
            tick();
            chk($sformatf("v%0d_vld0", i), 32'(vld0), 32'(vecs[i].exp_vld));
            chk($sformatf("v%0d_dat0", i), dat0, vecs[i].exp0);
            chk($sformatf("v%0d_vld1", i), 32'(vld1), 32'(vecs[i].exp_vld));
            chk($sformatf("v%0d_dat1", i), dat1, vecs[i].exp1);
            chk($sformatf("v%0d_busy0", i), 32'(busy0), 32'd0);
            chk($sformatf("v%0d_vld2", i), 32'(vld2), 32'(pv));
            chk($sformatf("v%0d_dat2", i), dat2, pd);
            pv = vecs[i].exp_vld; pd = vecs[i].exp0;
        end

        // clear_i together with a read of address 2
        idle_inputs();
        clear = 1'b1; ren = 1'b1; raddr = 4'd2;
        tick();
        chk("clr_rd_vld", 32'(vld0), 32'd1);
        chk("clr_rd_dat", dat0, 32'hCAFEF00D);
        chk("clr_busy", 32'(busy0), 32'd1);
        chk("clr_lag_vld2", 32'(vld2), 32'd1);
        chk("clr_lag_dat2", dat2, 32'hCAFEF00D);

        // sweep with a second clear pulse plus writes and reads that must be ignored
        clear = 1'b0; wen = 1'b1; be = 4'hF; waddr = 4'd0; wdata = 32'h0;
        n = 0;
        for (int e = 1; e <= 40; e++) begin
            clear = (e == 3);
            tick();
            n++;
            chk($sformatf("clr_sweep_vld0_e%0d", e), 32'(vld0), 32'd0);
            if (e == 1) begin
                chk("clr_rd_vld2", 32'(vld2), 32'd1);
                chk("clr_rd_dat2", dat2, 32'hCAFEF00D);
            end
            if (!busy0) break;
        end
        idle_inputs();
        chk("clr_sweep_len", 32'(n), 32'd16);

        for (int a = 0; a < 16; a++) begin
            ren = 1'b1; raddr = 4'(a);
            tick();
            chk($sformatf("post_clr_vld0_a%0d", a), 32'(vld0), 32'd1);
            chk($sformatf("post_clr_dat0_a%0d", a), dat0, IV);
            chk($sformatf("post_clr_dat1_a%0d", a), dat1, IV);
        end
        idle_inputs();

        // depth 10: reset at sweep cycle 4, full restart, out-of-range address
        rst3 = 1'b1;
        #1;
        chk("d10_rst_busy", 32'(busy3), 32'd1);
        chk("d10_rst_vld", 32'(vld3), 32'd0);
        chk("d10_rst_dat", dat3, 32'h0);
        tick();
        rst3 = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk($sformatf("d10_busy_e%0d", e), 32'(busy3), 32'd1);
        end
        rst3 = 1'b1;
        tick();
        rst3 = 1'b0;
        n = 0;
        for (int e = 1; e <= 30; e++) begin
            tick();
            n++;
            if (!busy3) break;
        end
        chk("d10_sweep_len", 32'(n), 32'd10);

        wen = 1'b1; be = 4'hF; waddr = 4'd12; wdata = 32'h12345678;
        tick();
        idle_inputs();
        ren = 1'b1; raddr = 4'd12;
        tick();
        chk("d10_oob_vld", 32'(vld3), 32'd1);
        chk("d10_oob_dat", dat3, 32'h0);
        raddr = 4'd4;
        tick();
        chk("d10_alias_dat", dat3, IV);
        raddr = 4'd9;
        tick();
        chk("d10_last_dat", dat3, IV);
        idle_inputs();

        // reset with a read in flight in the output-register instance
        ren = 1'b1; raddr = 4'd1;
        tick();
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("inflight_vld2", 32'(vld2), 32'd0);
        tick();
        chk("inflight_vld2_next", 32'(vld2), 32'd0);
        chk("inflight_dat2", dat2, 32'h0);
        chk("inflight_busy2", 32'(busy2), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
